// File: rtl/card_shuffler.sv
// card_shuffler: captures computed card words and Fisher-Yates shuffles them with an LFSR
module card_shuffler #(
  parameter int          NUM_CARDS = 12,
  parameter int          DATA_W    = 14,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              cc_enable,
  input  logic [DATA_W-1:0] cc_data,
  input  logic [3:0]        cc_address,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              ready
);
  localparam logic [3:0] LAST = 4'(NUM_CARDS);
  typedef enum logic [1:0] {IDLE, LOAD, SHUFFLE, READY} state_t;
  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [3:0]        i_q, i_d, j;
  logic [DATA_W-1:0] ent_q [16];
  logic [DATA_W-1:0] ent_d [16];
  logic [DATA_W-1:0] rd_q;
  logic              cap;
  assign cap       = state_q == LOAD && cc_address != 4'd0 && cc_address <= LAST;
  assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign j         = 4'd1 + 4'(({4'b0, lfsr_q[7:0]} * {8'b0, i_q}) >> 8);
  assign cc_enable = state_q == LOAD;
  assign busy      = state_q == LOAD || state_q == SHUFFLE;
  assign ready     = state_q == READY;
  assign rd_data   = rd_q;
  // next state and swap index: capture until the last card lands, then count i down to 2
  always_comb begin
    state_d = state_q;
    i_d     = state_q == LOAD ? LAST : i_q;
    if ((state_q == IDLE || state_q == READY) && start) state_d = LOAD;
    if (cap && cc_address == LAST) state_d = SHUFFLE;
    if (state_q == SHUFFLE) begin
      i_d     = i_q - 4'd1;
      state_d = i_q == 4'd2 ? READY : SHUFFLE;
    end
  end
  // card file next value: capture in LOAD, one swap per cycle in SHUFFLE, game writes in READY
  always_comb begin
    ent_d = ent_q;
    if (cap) ent_d[cc_address] = cc_data;
    if (state_q == SHUFFLE) begin
      ent_d[i_q] = ent_q[j];
      ent_d[j]   = ent_q[i_q];
    end
    if (state_q == READY && wr_en) ent_d[wr_addr] = wr_data;
  end
  // state, LFSR, card file and registered read port (read returns pre-write contents)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      i_q     <= LAST;
      rd_q    <= '0;
      ent_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      i_q     <= i_d;
      rd_q    <= ent_q[rd_addr];
      ent_q   <= ent_d;
    end
  end
endmodule

// File: tb/tb_card_shuffler.sv
// tb_card_shuffler: directed scoreboard bench for the card store and shuffler
module tb_card_shuffler;
  logic        clk = 0, rst = 1, start = 0, cc_enable, wr_en = 0, busy, ready;
  logic [13:0] cc_data, rd_data, wr_data = 0;
  logic [3:0]  cc_address, rd_addr = 0, wr_addr = 0;
  logic [15:0] m_lfsr, snap;
  logic [13:0] mdl [16];
  logic [13:0] got [16];
  logic [13:0] got_a [16];
  logic [11:0] cols [6] = '{12'hF00, 12'h0F0, 12'h00F, 12'h0FF, 12'hF0F, 12'hFF0};
  logic [13:0] exp_q [$];
  string       tag_q [$];
  int          n_cmp = 0, n_bad = 0;

  card_shuffler dut (
    .clk(clk), .rst(rst), .start(start), .cc_enable(cc_enable), .cc_data(cc_data),
    .cc_address(cc_address), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] adv(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [13:0] card(input int a);
    return {cols[(a - 1) % 6], 2'b01};
  endfunction

  // behavioural colour-computation stage: starts counting on cc_enable, runs on to 13, then idles
  always @(posedge clk or posedge rst)
    if (rst) cc_address <= 0;
    else if (cc_address == 13) cc_address <= 0;
    else if (cc_address != 0 || cc_enable) cc_address <= cc_address + 1;

  always_comb cc_data = (cc_address >= 1 && cc_address <= 12) ? card(int'(cc_address)) : 14'h2AAA;

  // reference LFSR, advancing on every edge out of reset
  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 16'hACE1;
    else m_lfsr <= adv(m_lfsr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd_check(input int a, input logic [13:0] e, input string tag);
    rd_addr = 4'(a);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    chk(tag_q.pop_front(), 32'(rd_data), 32'(exp_q.pop_front()));
    got[a] = rd_data;
  endtask

  task automatic check_deck(input string tag);
    for (int a = 0; a < 16; a++) rd_check(a, mdl[a], $sformatf("%s_e%0d", tag, a));
  endtask

  // Fisher-Yates reference: swap for i=12 uses the LFSR value 13 edges after the start edge
  task automatic model_deal(input logic [15:0] s);
    logic [15:0] l;
    logic [13:0] t;
    l = s;
    repeat (13) l = adv(l);
    for (int a = 1; a <= 12; a++) mdl[a] = card(a);
    for (int i = 12; i >= 2; i--) begin
      int r, jj;
      r = int'(l[7:0]);
      jj = 1 + (r * i) / 256;
      t = mdl[i]; mdl[i] = mdl[jj]; mdl[jj] = t;
      l = adv(l);
    end
  endtask

  // one deal from a start sampled at the next edge; optional write attempts presented mid-SHUFFLE
  task automatic deal(input bit keep, input int wcyc, input string tag);
    start = 1;
    @(posedge clk); #1;
    snap = m_lfsr;
    chk({tag, "_busy0"}, 32'(busy), 1);
    chk({tag, "_ready0"}, 32'(ready), 0);
    if (!keep) start = 0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      if (wcyc > 0 && n == wcyc) begin wr_en = 1; wr_addr = 5; wr_data = 14'h3FFF; end
      if (wcyc > 0 && n == wcyc + 1) wr_addr = 14;
      if (wcyc > 0 && n == wcyc + 2) wr_en = 0;
      if (n == 12) chk({tag, "_ccen12"}, 32'(cc_enable), 1);
      if (n == 13) chk({tag, "_ccen13"}, 32'(cc_enable), 0);
      if (n == 23) begin chk({tag, "_ready23"}, 32'(ready), 0); chk({tag, "_busy23"}, 32'(busy), 1); end
      if (n == 24) begin chk({tag, "_ready24"}, 32'(ready), 1); chk({tag, "_busy24"}, 32'(busy), 0); end
    end
    model_deal(snap);
  endtask

  initial begin
    int cnt, diff;
    for (int a = 0; a < 16; a++) mdl[a] = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_ccen", 32'(cc_enable), 0);
    chk("rst_rd", 32'(rd_data), 0);
    rst = 0;
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
    @(posedge clk); #1;
    deal(0, 0, "deal1");
    check_deck("deal1");
    for (int c = 0; c < 6; c++) begin
      cnt = 0;
      for (int a = 1; a <= 12; a++) if (got[a][13:2] == cols[c]) cnt++;
      chk($sformatf("colour%0d_count", c), 32'(cnt), 2);
    end
    wr_en = 1; wr_addr = 5; wr_data = 14'h3FFF; rd_addr = 5;
    exp_q.push_back(mdl[5]); tag_q.push_back("wr_same_edge");
    @(posedge clk); #1;
    wr_en = 0;
    chk(tag_q.pop_front(), 32'(rd_data), 32'(exp_q.pop_front()));
    mdl[5] = 14'h3FFF;
    rd_check(5, 14'h3FFF, "wr_next_edge");
    wr_en = 1; wr_addr = 0; wr_data = 14'h1234;
    @(posedge clk); #1;
    wr_en = 0;
    mdl[0] = 14'h1234;
    rd_check(0, 14'h1234, "wr_entry0");
    deal(1, 0, "held");
    deal(0, 16, "after_held");
    check_deck("shuf_wr");
    repeat (3) @(posedge clk); #1;
    deal(0, 0, "redeal_a");
    check_deck("redeal_a");
    for (int a = 0; a < 16; a++) got_a[a] = got[a];
    repeat (7) @(posedge clk); #1;
    deal(0, 0, "redeal_b");
    check_deck("redeal_b");
    diff = 0;
    for (int a = 1; a <= 12; a++) if (got[a] !== got_a[a]) diff = 1;
    chk("perm_differ", 32'(diff), 1);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (17) @(posedge clk); #1;
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1; #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_ready", 32'(ready), 0);
    chk("async_ccen", 32'(cc_enable), 0);
    repeat (2) @(posedge clk); #1;
    rst = 0;
    chk("post_rst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
    chk("post_rst_rd", 32'(rd_data), 0);
    for (int a = 0; a < 16; a++) rd_check(a, 14'h0, $sformatf("clr_e%0d", a));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
